// File: rtl/execute_cycle.sv
// execute_cycle: RV32I execute stage with operand forwarding, ALU, branch compare and EX/MEM register.
//   Inputs : i_clk, i_rst_n (async active-low), ID/EX controls and operands (*E),
//            ForwardAE/ForwardBE selects, ResultW for write-back forwarding,
//            i_flushE (only when EXECUTE_FLUSH_EN is defined).
//   Outputs: ALUResultE, BrEqualE, BrLessE (combinational),
//            RegWriteM, MemWriteM, insn_vldM, ResultSrcM, RD_ADDR_M,
//            ALUResultM, WriteDataM, PCPlus4M (registered EX/MEM bundle).
//   Macro  : EXECUTE_FLUSH_EN adds i_flushE, which clears the M control bits.
module execute_cycle (
    input  logic        i_clk,
    input  logic        i_rst_n,
    input  logic        RegWriteE,
    input  logic        MemWriteE,
    input  logic        br_unE,
    input  logic        opa_selE,
    input  logic        opb_selE,
    input  logic        insn_vldE,
    input  logic [1:0]  ResultSrcE,
    input  logic [3:0]  ALUControlE,
    input  logic [31:0] RS1_E,
    input  logic [31:0] RS2_E,
    input  logic [31:0] Imm_Ext_E,
    input  logic [31:0] PCE,
    input  logic [31:0] PCPlus4E,
    input  logic [4:0]  RD_ADDR_E,
    input  logic [1:0]  ForwardAE,
    input  logic [1:0]  ForwardBE,
    input  logic [31:0] ResultW,
`ifdef EXECUTE_FLUSH_EN
    input  logic        i_flushE,
`endif
    output logic [31:0] ALUResultE,
    output logic        BrEqualE,
    output logic        BrLessE,
    output logic        RegWriteM,
    output logic        MemWriteM,
    output logic        insn_vldM,
    output logic [1:0]  ResultSrcM,
    output logic [4:0]  RD_ADDR_M,
    output logic [31:0] ALUResultM,
    output logic [31:0] WriteDataM,
    output logic [31:0] PCPlus4M
);
    logic [31:0] w_src_a, w_src_b, w_alu_a, w_alu_b, w_alu;
    logic [4:0]  w_shamt;
    logic        w_kill;
    logic        r_reg_write, r_mem_write, r_insn_vld;
    logic [1:0]  r_result_src;
    logic [4:0]  r_rd_addr;
    logic [31:0] r_alu_result, r_write_data, r_pc_plus4;

    // Select 10 feeds back the EX/MEM result of the previous instruction.
    assign w_src_a = (ForwardAE == 2'b01) ? ResultW : (ForwardAE == 2'b10) ? r_alu_result : RS1_E;
    assign w_src_b = (ForwardBE == 2'b01) ? ResultW : (ForwardBE == 2'b10) ? r_alu_result : RS2_E;
    assign w_alu_a = opa_selE ? PCE : w_src_a;
    assign w_alu_b = opb_selE ? Imm_Ext_E : w_src_b;
    assign w_shamt = w_alu_b[4:0];

    always_comb begin
        w_alu = '0;
        case (ALUControlE)
            4'b0000: w_alu = w_alu_a + w_alu_b;
            4'b0001: w_alu = w_alu_a - w_alu_b;
            4'b0010: w_alu = w_alu_a << w_shamt;
            4'b0011: w_alu = {31'b0, $signed(w_alu_a) < $signed(w_alu_b)};
            4'b0100: w_alu = {31'b0, w_alu_a < w_alu_b};
            4'b0101: w_alu = w_alu_a ^ w_alu_b;
            4'b0110: w_alu = w_alu_a >> w_shamt;
            4'b0111: w_alu = $unsigned($signed(w_alu_a) >>> w_shamt);
            4'b1000: w_alu = w_alu_a | w_alu_b;
            4'b1001: w_alu = w_alu_a & w_alu_b;
            4'b1010: w_alu = w_alu_b;
            default: w_alu = '0;
        endcase
    end

    assign ALUResultE = w_alu;
    // Branch compare sees forwarded registers, not the PC/immediate muxed operands.
    assign BrEqualE = w_src_a == w_src_b;
    assign BrLessE  = br_unE ? (w_src_a < w_src_b) : ($signed(w_src_a) < $signed(w_src_b));

`ifdef EXECUTE_FLUSH_EN
    assign w_kill = i_flushE;
`else
    assign w_kill = 1'b0;
`endif

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_reg_write  <= 1'b0;
            r_mem_write  <= 1'b0;
            r_insn_vld   <= 1'b0;
            r_result_src <= '0;
            r_rd_addr    <= '0;
            r_alu_result <= '0;
            r_write_data <= '0;
            r_pc_plus4   <= '0;
        end else begin
            r_reg_write  <= RegWriteE & ~w_kill;
            r_mem_write  <= MemWriteE & ~w_kill;
            r_insn_vld   <= insn_vldE & ~w_kill;
            r_result_src <= w_kill ? 2'b00 : ResultSrcE;
            r_rd_addr    <= RD_ADDR_E;
            r_alu_result <= w_alu;
            r_write_data <= w_src_b;
            r_pc_plus4   <= PCPlus4E;
        end
    end

    assign RegWriteM  = r_reg_write;
    assign MemWriteM  = r_mem_write;
    assign insn_vldM  = r_insn_vld;
    assign ResultSrcM = r_result_src;
    assign RD_ADDR_M  = r_rd_addr;
    assign ALUResultM = r_alu_result;
    assign WriteDataM = r_write_data;
    assign PCPlus4M   = r_pc_plus4;
endmodule

// File: tb/tb_execute_cycle.sv
// tb_execute_cycle: scoreboard bench for execute_cycle with a behavioural reference model.
module tb_execute_cycle;
    typedef struct {
        logic        rw, mw, bu, oa, ob, iv, fl;
        logic [1:0]  rs, fa, fb;
        logic [3:0]  op;
        logic [31:0] a, b, imm, pc, pc4, resw;
        logic [4:0]  rd;
    } stim_t;

    typedef struct {
        logic        rw, mw, iv;
        logic [1:0]  rs;
        logic [4:0]  rd;
        logic [31:0] alu, wd, pc4;
    } exp_t;

    logic        i_clk = 0, i_rst_n = 0;
    logic        RegWriteE, MemWriteE, br_unE, opa_selE, opb_selE, insn_vldE, flush;
    logic [1:0]  ResultSrcE, ForwardAE, ForwardBE;
    logic [3:0]  ALUControlE;
    logic [31:0] RS1_E, RS2_E, Imm_Ext_E, PCE, PCPlus4E, ResultW;
    logic [4:0]  RD_ADDR_E;
    logic [31:0] ALUResultE, ALUResultM, WriteDataM, PCPlus4M;
    logic        BrEqualE, BrLessE, RegWriteM, MemWriteM, insn_vldM;
    logic [1:0]  ResultSrcM;
    logic [4:0]  RD_ADDR_M;

    int checks = 0, errors = 0;
    exp_t q[$];
    logic [31:0] m_alu = 0;

    execute_cycle dut (
        .i_clk(i_clk), .i_rst_n(i_rst_n),
        .RegWriteE(RegWriteE), .MemWriteE(MemWriteE), .br_unE(br_unE),
        .opa_selE(opa_selE), .opb_selE(opb_selE), .insn_vldE(insn_vldE),
        .ResultSrcE(ResultSrcE), .ALUControlE(ALUControlE),
        .RS1_E(RS1_E), .RS2_E(RS2_E), .Imm_Ext_E(Imm_Ext_E), .PCE(PCE), .PCPlus4E(PCPlus4E),
        .RD_ADDR_E(RD_ADDR_E), .ForwardAE(ForwardAE), .ForwardBE(ForwardBE), .ResultW(ResultW),
`ifdef EXECUTE_FLUSH_EN
        .i_flushE(flush),
`endif
        .ALUResultE(ALUResultE), .BrEqualE(BrEqualE), .BrLessE(BrLessE),
        .RegWriteM(RegWriteM), .MemWriteM(MemWriteM), .insn_vldM(insn_vldM),
        .ResultSrcM(ResultSrcM), .RD_ADDR_M(RD_ADDR_M),
        .ALUResultM(ALUResultM), .WriteDataM(WriteDataM), .PCPlus4M(PCPlus4M)
    );

    always #5 i_clk = ~i_clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got=%h expected=%h", name, act, exp);
        end
    endtask

    // Reference ALU written from the operation table using wide signed arithmetic.
    function automatic logic [31:0] ref_alu(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
        longint sa = longint'($signed(a));
        longint sb = longint'($signed(b));
        longint ua = longint'(a);
        longint ub = longint'(b);
        int sh = int'(b % 32);
        case (op)
            0: return 32'(ua + ub);
            1: return 32'(ua - ub);
            2: return 32'(ua * (64'd1 << sh));
            3: return (sa < sb) ? 32'd1 : 32'd0;
            4: return (ua < ub) ? 32'd1 : 32'd0;
            5: return a ^ b;
            6: return 32'(ua / (64'd1 << sh));
            7: return 32'(sa >>> sh);
            8: return a | b;
            9: return a & b;
            10: return b;
            default: return 32'd0;
        endcase
    endfunction

    function automatic stim_t zs();
        stim_t s;
        {s.rw, s.mw, s.bu, s.oa, s.ob, s.iv, s.fl} = '0;
        {s.rs, s.fa, s.fb, s.op, s.rd} = '0;
        {s.a, s.b, s.imm, s.pc, s.pc4, s.resw} = '0;
        return s;
    endfunction

    function automatic stim_t rs_rand();
        stim_t s;
        {s.rw, s.mw, s.bu, s.oa, s.ob, s.iv} = 6'($urandom);
        s.fl = 1'b0;
`ifdef EXECUTE_FLUSH_EN
        s.fl = ($urandom_range(0, 4) == 0);
`endif
        s.rs = 2'($urandom); s.fa = 2'($urandom); s.fb = 2'($urandom);
        s.op = 4'($urandom); s.rd = 5'($urandom);
        s.a = $urandom; s.b = $urandom; s.imm = $urandom;
        s.pc = $urandom; s.pc4 = $urandom; s.resw = $urandom;
        if ($urandom_range(0, 3) == 0) s.b = s.a;
        return s;
    endfunction

    task automatic drive(input stim_t s);
        RegWriteE = s.rw; MemWriteE = s.mw; br_unE = s.bu; opa_selE = s.oa; opb_selE = s.ob;
        insn_vldE = s.iv; flush = s.fl; ResultSrcE = s.rs; ForwardAE = s.fa; ForwardBE = s.fb;
        ALUControlE = s.op; RS1_E = s.a; RS2_E = s.b; Imm_Ext_E = s.imm; PCE = s.pc;
        PCPlus4E = s.pc4; ResultW = s.resw; RD_ADDR_E = s.rd;
    endtask

    // Drives one instruction, checks same-cycle outputs, queues the expected EX/MEM bundle.
    task automatic apply(input stim_t s);
        logic [31:0] sa, sb, r;
        exp_t e;
        @(negedge i_clk);
        drive(s);
        #1;
        sa = (s.fa == 1) ? s.resw : (s.fa == 2) ? m_alu : s.a;
        sb = (s.fb == 1) ? s.resw : (s.fb == 2) ? m_alu : s.b;
        r = ref_alu(s.op, s.oa ? s.pc : sa, s.ob ? s.imm : sb);
        chk("ALUResultE", ALUResultE, r);
        chk("BrEqualE", 32'(BrEqualE), 32'(sa == sb));
        chk("BrLessE", 32'(BrLessE), s.bu ? 32'(sa < sb) : 32'($signed(sa) < $signed(sb)));
        e.rw = s.rw; e.mw = s.mw; e.iv = s.iv; e.rs = s.rs;
`ifdef EXECUTE_FLUSH_EN
        if (s.fl) begin e.rw = 0; e.mw = 0; e.iv = 0; e.rs = 0; end
`endif
        e.rd = s.rd; e.alu = r; e.wd = sb; e.pc4 = s.pc4;
        q.push_back(e);
        m_alu = r;
    endtask

    initial begin : monitor
        exp_t e;
        forever begin
            @(posedge i_clk);
            #1;
            if (q.size() > 0) begin
                e = q.pop_front();
                chk("RegWriteM", 32'(RegWriteM), 32'(e.rw));
                chk("MemWriteM", 32'(MemWriteM), 32'(e.mw));
                chk("insn_vldM", 32'(insn_vldM), 32'(e.iv));
                chk("ResultSrcM", 32'(ResultSrcM), 32'(e.rs));
                chk("RD_ADDR_M", 32'(RD_ADDR_M), 32'(e.rd));
                chk("ALUResultM", ALUResultM, e.alu);
                chk("WriteDataM", WriteDataM, e.wd);
                chk("PCPlus4M", PCPlus4M, e.pc4);
            end
        end
    end

    task automatic chk_m_zero(input string tag);
        chk({tag, " RegWriteM"}, 32'(RegWriteM), 0);
        chk({tag, " MemWriteM"}, 32'(MemWriteM), 0);
        chk({tag, " insn_vldM"}, 32'(insn_vldM), 0);
        chk({tag, " ResultSrcM"}, 32'(ResultSrcM), 0);
        chk({tag, " RD_ADDR_M"}, 32'(RD_ADDR_M), 0);
        chk({tag, " ALUResultM"}, ALUResultM, 0);
        chk({tag, " WriteDataM"}, WriteDataM, 0);
        chk({tag, " PCPlus4M"}, PCPlus4M, 0);
    endtask

    task automatic release_reset();
        @(negedge i_clk);
        drive(zs());
        m_alu = 0;
        i_rst_n = 1;
    endtask

    initial begin : stim
        stim_t s;
        s = rs_rand(); s.rw = 1; s.mw = 1; s.iv = 1; s.fl = 0; s.pc4 = 32'h1234;
        drive(s);
        repeat (2) @(posedge i_clk);
        #1 chk_m_zero("reset");
        release_reset();

        s = zs(); s.a = 5; s.b = 7; s.iv = 1; s.rw = 1;
        apply(s); chk("add 5+7", ALUResultE, 32'd12);
        @(posedge i_clk); #2 chk("add M", ALUResultM, 32'd12);

        s = zs(); s.op = 1; s.a = 10; s.b = 3;
        apply(s); chk("sub 10-3", ALUResultE, 32'd7);
        s = zs(); s.fa = 2; s.ob = 1; s.imm = 1;
        apply(s); chk("fwd M+1", ALUResultE, 32'd8);
        s = zs(); s.fb = 1; s.resw = 32'hDEAD_BEEF; s.mw = 1;
        apply(s);
        @(posedge i_clk); #2 chk("store fwd", WriteDataM, 32'hDEAD_BEEF);

        s = zs(); s.a = 32'h8000_0000; s.b = 4; s.op = 7;
        apply(s); chk("sra", ALUResultE, 32'hF800_0000);
        s.op = 6; apply(s); chk("srl", ALUResultE, 32'h0800_0000);
        s = zs(); s.a = 32'hFFFF_FFFF; s.b = 1; s.op = 3;
        apply(s); chk("slt", ALUResultE, 32'd1);
        chk("brless signed", 32'(BrLessE), 1);
        chk("brequal", 32'(BrEqualE), 0);
        s.op = 4; s.bu = 1;
        apply(s); chk("sltu", ALUResultE, 32'd0);
        chk("brless unsigned", 32'(BrLessE), 0);
        s.op = 15; apply(s); chk("op 1111", ALUResultE, 32'd0);
        s = zs(); s.oa = 1; s.pc = 32'h100; s.ob = 1; s.imm = 32'hFFFF_FFF8;
        apply(s); chk("pc+imm", ALUResultE, 32'hF8);

`ifdef EXECUTE_FLUSH_EN
        s = zs(); s.rw = 1; s.mw = 1; s.iv = 1; s.fl = 1;
        apply(s);
        @(posedge i_clk); #2 chk("flushed ctl", {29'b0, RegWriteM, MemWriteM, insn_vldM}, 0);
        s.fl = 0; apply(s);
        @(posedge i_clk); #2 chk("unflushed ctl", {29'b0, RegWriteM, MemWriteM, insn_vldM}, 32'd7);
`endif

        repeat (300) apply(rs_rand());

        s = zs(); s.rw = 1; s.a = 1; s.b = 1;
        apply(s);
        @(posedge i_clk); #3;
        i_rst_n = 0;
        #1 chk_m_zero("async reset");
        release_reset();
        repeat (100) apply(rs_rand());

        @(posedge i_clk); #3;
        chk("queue drained", 32'(q.size()), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/execute_cycle.md
# execute_cycle

Execute stage of the five-stage RV32I pipeline. It consumes the ID/EX bundle produced by the decode stage, applies operand forwarding, runs the ALU and the branch comparator, and registers the EX/MEM pipeline bundle for the memory stage. The same-cycle branch-compare flags and ALU result go to the PC-select/hazard logic.

## Interface
- No parameters; data width fixed at 32 bits, register address width at 5 bits.
- i_clk  in  1  pipeline clock
- i_rst_n  in  1  asynchronous active-low reset
- RegWriteE, MemWriteE, br_unE, opa_selE, opb_selE, insn_vldE  in  1 each  decoded controls from ID/EX
- ResultSrcE  in  2  write-back select, passed through
- ALUControlE  in  4  ALU operation
- RS1_E, RS2_E, Imm_Ext_E, PCE, PCPlus4E  in  32 each  operands and PC values from ID/EX
- RD_ADDR_E  in  5  destination register
- ForwardAE, ForwardBE  in  2 each  forward select from the hazard unit
- ResultW  in  32  write-back stage result for forwarding
- i_flushE  in  1  kill the instruction leaving EX (present only with EXECUTE_FLUSH_EN)
- ALUResultE  out  32  combinational ALU result; also the branch/jump target
- BrEqualE, BrLessE  out  1 each  combinational compare flags
- RegWriteM, MemWriteM, insn_vldM  out  1 each  registered controls
- ResultSrcM  out  2  registered write-back select
- RD_ADDR_M  out  5  registered destination
- ALUResultM, WriteDataM, PCPlus4M  out  32 each  registered data

## Operation
- Forwarded source A (SrcAF): ForwardAE 00 → RS1_E; 01 → ResultW; 10 → ALUResultM (internal register); 11 → RS1_E. Source B (SrcBF) works the same way with ForwardBE and RS2_E.
- ALU A is PCE when opa_selE=1, otherwise SrcAF. ALU B is Imm_Ext_E when opb_selE=1, otherwise SrcBF.
- ALUControlE encoding:
  - 0000 ADD, 0001 SUB, 0010 SLL, 0011 SLT (signed), 0100 SLTU, 0101 XOR, 0110 SRL, 0111 SRA, 1000 OR, 1001 AND, 1010 pass B (LUI).
  - 1011–1111 produce 0.
- Shift amount is B[4:0]. Add and sub wrap modulo 2^32. SLT and SLTU return 32'h1 or 32'h0.
- The comparator always uses the forwarded values SrcAF and SrcBF, never the opa/opb muxed operands.
  - BrEqualE = (SrcAF == SrcBF).
  - BrLessE is an unsigned compare when br_unE=1, otherwise a signed compare.
- WriteDataM captures SrcBF, so store data is forwarded.
- EX/MEM register loads every cycle; there is no stall input. Stalls are handled upstream by bubbling ID/EX.
- A flushed or bubbled slot (insn_vldE=0) is still registered as-is. Side effects are gated downstream by RegWriteM, MemWriteM and insn_vldM.
- RD_ADDR_E = 0 passes through unchanged. The register file ignores writes to x0.

## Timing
- Combinational path: ForwardAE/BE, operands → ALUResultE, BrEqualE, BrLessE within the same cycle.
- Registered path: EX → M latency is exactly one i_clk rising edge.
- Forward select 10 reads ALUResultM as it stands before the current edge, i.e. the result of the previous instruction.
- Reset: the asynchronous assert of i_rst_n immediately drives every registered output to 0, including RegWriteM, MemWriteM, insn_vldM, ResultSrcM, RD_ADDR_M, ALUResultM, WriteDataM and PCPlus4M. Combinational outputs follow their inputs.
- Reset mid-operation discards the in-flight EX/MEM contents. The first post-reset edge captures whatever is presented on the E inputs.
- Reset dominates flush.

## Configuration
- EXECUTE_FLUSH_EN defined:
  - The i_flushE port exists.
  - i_flushE=1 at an edge loads RegWriteM=0, MemWriteM=0, insn_vldM=0 and ResultSrcM=0.
  - Data fields still load normally.
  - Flush takes priority over normal capture.
- EXECUTE_FLUSH_EN undefined: the port is absent and the EX/MEM register always captures the E inputs.

## Test plan
- Reset: hold i_rst_n=0 with nonzero inputs → all M outputs 0. Release, present ADD with RS1_E=5, RS2_E=7, forwards 00 → ALUResultE=12 same cycle, ALUResultM=12 after one edge.
- Back-to-back forwarding: first cycle SUB 10−3 → ALUResultM=7. Next cycle ForwardAE=10, ALUControlE=ADD, opb_selE=1, Imm_Ext_E=1 → ALUResultE=8. Then ForwardBE=01, ResultW=32'hDEAD_BEEF, MemWriteE=1 → WriteDataM=32'hDEAD_BEEF.
- Shifts and compares:
  - SRA of 32'h8000_0000 by 4 → 32'hF800_0000; SRL of the same → 32'h0800_0000.
  - SLT of −1 vs 1 → 1; SLTU of the same pair → 0.
  - Op code 1111 → 0.
- Branch flags:
  - SrcAF=32'hFFFF_FFFF, SrcBF=1 with br_unE=0 → BrLessE=1, BrEqualE=0.
  - Same operands with br_unE=1 → BrLessE=0.
  - opa_selE=1, PCE=32'h100, Imm_Ext_E=32'hFFFF_FFF8 → ALUResultE=32'hF8.
- Flush (EXECUTE_FLUSH_EN): RegWriteE=1, MemWriteE=1, insn_vldE=1 with i_flushE=1 → after the edge RegWriteM=0, MemWriteM=0, insn_vldM=0. With i_flushE=0 the next edge gives all three 1.
- Async reset mid-stream: drop i_rst_n between edges while RegWriteM=1 → RegWriteM=0 and ALUResultM=0 immediately, without waiting for a clock edge.
